// File: rtl/hdr_pkg.sv
// Shared types and constants for the HDR capture / VGA display pipeline.
package hdr_pkg;

  localparam int H_ACT_DFLT = 640;
  localparam int V_ACT_DFLT = 480;
  localparam int SRAM_AW    = 20;
  localparam int SRAM_DW    = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } capture_state_e;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] data;
  } fifo_entry_t;

  // The display path expects the pixel in the low byte of each word.
  function automatic logic [SRAM_DW-1:0] pack_pixel(input logic [7:0] pix);
    return {8'h00, pix};
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO of DEPTH entries of type T; DEPTH must be a power of two >= 2.
// A push is accepted when not full, or when a pop is honoured in the same cycle.
module capture_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic          do_push_s, do_pop_s;

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/vga_capture.sv
// Captures one H_ACT x V_ACT frame from an 8-bit fval/lval stream into SRAM words.
// Build option CAPTURE_TESTPAT_EN replaces the captured pixel with x[7:0]^y[7:0].
module vga_capture
  import hdr_pkg::*;
#(
  parameter int H_ACT      = H_ACT_DFLT,
  parameter int V_ACT      = V_ACT_DFLT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk_25M,
  input  logic               i_rst,
  input  logic               i_start_capture,
  input  logic               i_fval,
  input  logic               i_lval,
  input  logic [7:0]         i_pixel,
  output logic               o_wr_req,
  output logic [SRAM_AW-1:0] o_addr_capture,
  output logic [SRAM_DW-1:0] o_wdata,
  input  logic               i_wr_ack,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow
);

  localparam logic [SRAM_AW-1:0] H_W   = SRAM_AW'(H_ACT);
  localparam logic [SRAM_AW-1:0] V_W   = SRAM_AW'(V_ACT);
  localparam logic [SRAM_AW-1:0] ONE_W = SRAM_AW'(1);

  capture_state_e     state_q, state_d;
  logic               fval_q, lval_q, fval_prev_q, lval_prev_q;
  logic [7:0]         pix_q;
  logic [SRAM_AW-1:0] x_q, x_d, y_q, y_d, base_q, base_d;
  logic               ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

  logic               frame_rise_s, frame_fall_s, line_fall_s, active_s;
  logic               push_s, pop_s, full_s, empty_s;
  logic [7:0]         pix_sel_s;
  fifo_entry_t        push_entry_s, head_s;

`ifdef CAPTURE_TESTPAT_EN
  assign pix_sel_s = x_q[7:0] ^ y_q[7:0];
`else
  assign pix_sel_s = pix_q;
`endif

  assign push_entry_s.addr = base_q + x_q;
  assign push_entry_s.data = pack_pixel(pix_sel_s);

  // Capture control: counters, push decision, overflow and state transitions.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    base_d       = base_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    push_s       = 1'b0;
    frame_rise_s = fval_q && !fval_prev_q;
    frame_fall_s = !fval_q && fval_prev_q;
    line_fall_s  = !lval_q && lval_prev_q;
    pop_s        = !empty_s && i_wr_ack;
    // The rising-edge cycle already carries the first pixel of the frame.
    active_s     = (state_q == S_CAPTURE) || ((state_q == S_ARM) && frame_rise_s);

    if (active_s && fval_q && lval_q && (x_q < H_W) && (y_q < V_W)) begin
      push_s = 1'b1;
      x_d    = x_q + ONE_W;
      if (full_s && !pop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else if (active_s && line_fall_s && (x_q != '0)) begin
      base_d = base_q + H_W;
      y_d    = y_q + ONE_W;
      x_d    = '0;
    end else begin
      x_d = x_q;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start_capture) begin
          state_d = S_ARM;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (frame_rise_s) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_ARM;
        end
      end
      S_CAPTURE: begin
        if (frame_fall_s || (y_d >= V_W)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_DRAIN: begin
        if (empty_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Input stream registers and edge-detect history.
  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      pix_q       <= 8'h00;
      fval_prev_q <= 1'b0;
      lval_prev_q <= 1'b0;
    end else begin
      fval_q      <= i_fval;
      lval_q      <= i_lval;
      pix_q       <= i_pixel;
      fval_prev_q <= fval_q;
      lval_prev_q <= lval_q;
    end
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fifo_entry_t)
  ) u_fifo (
    .clk   (i_clk_25M),
    .rst   (i_rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  assign o_wr_req       = !empty_s;
  assign o_addr_capture = head_s.addr;
  assign o_wdata        = head_s.data;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: randomized frames against an address-map model.
`timescale 1ns/1ps
module tb_vga_capture;

  localparam int H    = 16;
  localparam int V    = 6;
  localparam int D    = 4;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst, start, fval, lval, ack;
  logic [7:0]  pix;
  logic        wr_req, busy, done, ovf;
  logic [19:0] addr;
  logic [15:0] wdata;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          done_cnt = 0;
  logic        done_fval = 1'b0;
  bit          rand_on = 1'b0;
  logic [15:0] exp_mem [NPIX];
  bit          exp_set [NPIX];
  int          exp_cnt = 0;

  always #20 clk = ~clk;

  vga_capture #(.H_ACT(H), .V_ACT(V), .FIFO_DEPTH(D)) dut (
    .i_clk_25M       (clk),
    .i_rst           (rst),
    .i_start_capture (start),
    .i_fval          (fval),
    .i_lval          (lval),
    .i_pixel         (pix),
    .o_wr_req        (wr_req),
    .o_addr_capture  (addr),
    .o_wdata         (wdata),
    .i_wr_ack        (ack),
    .o_busy          (busy),
    .o_done          (done),
    .o_overflow      (ovf)
  );

  // Record every accepted SRAM write and every done pulse.
  always @(negedge clk) begin
    if (wr_req === 1'b1 && ack === 1'b1) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(wdata);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_fval = fval;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fval = 1'b0;
    lval = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NPIX; i++) begin
      exp_mem[i] = 16'h0000;
      exp_set[i] = 1'b0;
    end
    exp_cnt = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt  = 0;
    done_fval = 1'b0;
  endtask

  // Expected word for the pixel at column x of the y-th non-empty line.
  task automatic model_pixel(input int x, input int y, input logic [7:0] p);
    if (x < H && y < V) begin
`ifdef CAPTURE_TESTPAT_EN
      exp_mem[y*H + x] = {8'h00, 8'(x ^ y)};
`else
      exp_mem[y*H + x] = {8'h00, p};
`endif
      exp_set[y*H + x] = 1'b1;
      exp_cnt++;
    end
  endtask

  task automatic send_frame(input int nlines, input int len, input bit rand_len,
                            input bit rec, input int gap);
    int y = 0;
    fval = 1'b1;
    lval = 1'b0;
    tick();
    tick();
    for (int l = 0; l < nlines; l++) begin
      int n = rand_len ? int'($urandom_range(1, H)) : len;
      for (int x = 0; x < n; x++) begin
        lval = 1'b1;
        pix  = 8'($urandom);
        if (rec) model_pixel(x, y, pix);
        tick();
      end
      lval = 1'b0;
      y++;
      repeat (gap) tick();
    end
    fval = 1'b0;
    pix  = 8'h00;
    tick();
  endtask

  task automatic wait_done(input int want);
    int n = 0;
    while (done_cnt < want && n < 1000) begin
      tick();
      n++;
    end
    repeat (6) tick();
  endtask

  // Number of recorded writes that disagree with the model or break address order.
  function automatic int bad_writes();
    int b = 0;
    int prev = -1;
    foreach (wr_addr_q[i]) begin
      int a = int'(wr_addr_q[i]);
      if (a >= NPIX) b++;
      else if (!exp_set[a] || wr_data_q[i] !== exp_mem[a] || a <= prev) b++;
      prev = a;
    end
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (wr_req !== 1'b0 || addr !== 20'd0 || wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_fifo: wr_req=%b addr=%0d wdata=%h, required 0 0 0", wr_req, addr, wdata);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b ovf=%b, required 0 0 0", busy, done, ovf);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: wr_req=%b busy=%b done_cnt=%0d, required 0 0 0", wr_req, busy, done_cnt);
    end
  endtask

  task automatic test_full_frame();
    int found = 0;
    logic [15:0] got = 16'hxxxx;
    clear_all();
    ack = 1'b1;
    idle(3);
    pulse_start();
    idle(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL full_armed_busy: got %b required 1", busy);
    end
    send_frame(V, H, 1'b0, 1'b1, 3);
    wait_done(1);
    checks++;
    if (wr_addr_q.size() !== NPIX) begin
      errors++;
      $display("FAIL full_count: got %0d writes required %0d", wr_addr_q.size(), NPIX);
    end
    checks++;
    if (bad_writes() !== 0) begin
      errors++;
      $display("FAIL full_data: %0d bad writes, required 0", bad_writes());
    end
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] == 20'(2*H + 5)) begin
        found++;
        got = wr_data_q[i];
      end
    end
    checks++;
    if (found !== 1 || got !== exp_mem[2*H + 5]) begin
      errors++;
      $display("FAIL full_x5_y2: seen %0d times data %h, required once data %h", found, got, exp_mem[2*H + 5]);
    end
    checks++;
    if (done_cnt !== 1 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_status: done_cnt=%0d ovf=%b busy=%b, required 1 0 0", done_cnt, ovf, busy);
    end
  endtask

  task automatic test_stall();
    logic [19:0] a0;
    int bad_hold = 0;
    int n;
    clear_all();
    ack = 1'b1;
    pulse_start();
    idle(3);
    fork
      send_frame(V, H, 1'b0, 1'b1, 3);
      begin
        repeat (2 + 2*(H + 3) + 4) tick();
        ack = 1'b0;
        a0 = addr;
        for (int i = 0; i < 10; i++) begin
          tick();
          if (wr_req !== 1'b1 || addr !== a0) bad_hold++;
          else if (addr >= 20'(NPIX)) bad_hold++;
          else if (wdata !== exp_mem[addr]) bad_hold++;
        end
        ack = 1'b1;
      end
    join
    wait_done(1);
    n = wr_addr_q.size();
    checks++;
    if (bad_hold !== 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable or wrong head cycles, required 0", bad_hold);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL stall_overflow: got %b required 1", ovf);
    end
    checks++;
    if (n >= NPIX - 2 || n < NPIX - 10) begin
      errors++;
      $display("FAIL stall_count: got %0d writes, required %0d..%0d", n, NPIX - 10, NPIX - 3);
    end
    checks++;
    if (bad_writes() !== 0) begin
      errors++;
      $display("FAIL stall_data: %0d bad writes, required 0", bad_writes());
    end
    checks++;
    if (n == 0 || wr_addr_q[n-1] !== 20'(NPIX - 1) || done_cnt !== 1) begin
      errors++;
      $display("FAIL stall_tail: last addr %0d done_cnt %0d, required %0d and 1",
               (n == 0) ? -1 : int'(wr_addr_q[n-1]), done_cnt, NPIX - 1);
    end
  endtask

  task automatic test_midframe_start();
    int n_first;
    clear_all();
    ack = 1'b1;
    idle(3);
    fork
      send_frame(V, H, 1'b0, 1'b0, 3);
      begin
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    n_first = wr_addr_q.size();
    checks++;
    if (n_first !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_skip: %0d writes busy=%b during skipped frame, required 0 and 1", n_first, busy);
    end
    idle(4);
    send_frame(V, H, 1'b0, 1'b1, 2);
    wait_done(1);
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 20'd0) begin
      errors++;
      $display("FAIL mid_first_addr: got %0d required 0", (wr_addr_q.size() == 0) ? -1 : int'(wr_addr_q[0]));
    end
    checks++;
    if (wr_addr_q.size() !== exp_cnt || bad_writes() !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL mid_frame: writes %0d bad %0d done %0d, required %0d 0 1",
               wr_addr_q.size(), bad_writes(), done_cnt, exp_cnt);
    end
  endtask

  task automatic test_oversize();
    int maxa = 0;
    clear_all();
    ack = 1'b1;
    pulse_start();
    idle(3);
    send_frame(V + 2, H + 4, 1'b0, 1'b1, 4);
    wait_done(1);
    foreach (wr_addr_q[i]) if (int'(wr_addr_q[i]) > maxa) maxa = int'(wr_addr_q[i]);
    checks++;
    if (maxa > NPIX - 1) begin
      errors++;
      $display("FAIL over_max_addr: got %0d required <= %0d", maxa, NPIX - 1);
    end
    checks++;
    if (wr_addr_q.size() !== NPIX || bad_writes() !== 0) begin
      errors++;
      $display("FAIL over_writes: got %0d writes %0d bad, required %0d 0", wr_addr_q.size(), bad_writes(), NPIX);
    end
    checks++;
    if (done_cnt !== 1 || done_fval !== 1'b1) begin
      errors++;
      $display("FAIL over_done: done_cnt %0d fval at done %b, required 1 1", done_cnt, done_fval);
    end
  endtask

  task automatic test_short_frame();
    clear_all();
    ack = 1'b1;
    pulse_start();
    idle(2);
    send_frame(V - 2, 0, 1'b1, 1'b1, 2);
    wait_done(1);
    checks++;
    if (wr_addr_q.size() !== exp_cnt || bad_writes() !== 0) begin
      errors++;
      $display("FAIL short_writes: got %0d writes %0d bad, required %0d 0", wr_addr_q.size(), bad_writes(), exp_cnt);
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL short_status: done %0d busy %b ovf %b, required 1 0 0", done_cnt, busy, ovf);
    end
  endtask

  task automatic test_random_ack();
    int n;
    clear_all();
    ack = 1'b1;
    pulse_start();
    idle(3);
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        ack = 1'($urandom_range(0, 1));
        tick();
      end
      begin
        fval = 1'b1;
        lval = 1'b0;
        tick();
        tick();
        for (int l = 0; l < V; l++) begin
          for (int x = 0; x < D; x++) begin
            lval = 1'b1;
            pix  = 8'($urandom);
            model_pixel(x, l, pix);
            tick();
          end
          lval = 1'b0;
          tick();
          tick();
          n = 0;
          while (wr_req === 1'b1 && n < 200) begin
            tick();
            n++;
          end
        end
        fval = 1'b0;
        tick();
        rand_on = 1'b0;
      end
    join
    ack = 1'b1;
    wait_done(1);
    checks++;
    if (wr_addr_q.size() !== exp_cnt || bad_writes() !== 0) begin
      errors++;
      $display("FAIL rack_writes: got %0d writes %0d bad, required %0d 0", wr_addr_q.size(), bad_writes(), exp_cnt);
    end
    checks++;
    if (ovf !== 1'b0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL rack_status: ovf %b done %0d, required 0 1", ovf, done_cnt);
    end
  endtask

  task automatic test_reset_midqueue();
    clear_all();
    ack = 1'b0;
    pulse_start();
    idle(2);
    fval = 1'b1;
    lval = 1'b0;
    tick();
    tick();
    for (int x = 0; x < 3; x++) begin
      lval = 1'b1;
      pix  = 8'($urandom);
      tick();
    end
    lval = 1'b0;
    tick();
    tick();
    checks++;
    if (wr_req !== 1'b1 || busy !== 1'b1 || addr !== 20'd0) begin
      errors++;
      $display("FAIL rstq_pre: wr_req %b busy %b addr %0d, required 1 1 0", wr_req, busy, addr);
    end
    #5 rst = 1'b1;
    #2;
    checks++;
    if (wr_req !== 1'b0) begin
      errors++;
      $display("FAIL rstq_async: wr_req %b required 0", wr_req);
    end
    tick();
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || addr !== 20'd0 || wdata !== 16'h0000) begin
      errors++;
      $display("FAIL rstq_state: wr_req %b busy %b done %b ovf %b addr %0d wdata %h, required all 0",
               wr_req, busy, done, ovf, addr, wdata);
    end
    rst = 1'b0;
    ack = 1'b1;
    tick();
    idle(3);
    send_frame(2, 4, 1'b0, 1'b0, 2);
    idle(4);
    checks++;
    if (wr_addr_q.size() !== 0 || busy !== 1'b0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL rstq_idle: writes %0d busy %b done %0d, required 0 0 0", wr_addr_q.size(), busy, done_cnt);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fval  = 1'b0;
    lval  = 1'b0;
    pix   = 8'h00;
    ack   = 1'b0;
    test_reset();
    test_full_frame();
    test_stall();
    test_midframe_start();
    test_oversize();
    test_short_frame();
    test_random_ack();
    test_reset_midqueue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Frame-capture front end for the HDR pipeline: waits for a start pulse, locks onto the next frame of an 8-bit line/frame-valid pixel stream, and writes exactly one H_ACT×V_ACT frame into SRAM. Each pixel goes to one 16-bit word at address y·H_ACT+x. The pixel sits in bits [7:0], the same layout the VGA display path reads back. A small FIFO decouples the pixel rate from the SRAM write arbiter's request/acknowledge handshake.

## Interface
Parameters:
- H_ACT, 640, active pixels per line; pixels beyond this count are dropped.
- V_ACT, 480, active lines per frame; lines beyond this count are dropped.
- FIFO_DEPTH, 4, write-buffer entries; must be a power of two, ≥2.

Ports:
- i_clk_25M  in  1  pixel/system clock (25 MHz); the only clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start_capture  in  1  single-cycle pulse that arms a capture.
- i_fval  in  1  frame valid from source.
- i_lval  in  1  line valid from source.
- i_pixel  in  8  pixel data, valid when i_fval&i_lval.
- o_wr_req  out  1  FIFO head valid / SRAM write request.
- o_addr_capture  out  20  SRAM word address of head entry.
- o_wdata  out  16  {8'h00, pixel} of head entry.
- i_wr_ack  in  1  SRAM accepted head this cycle.
- o_busy  out  1  high in S_ARM and S_CAPTURE and while draining.
- o_done  out  1  one-cycle pulse when the frame is fully written.
- o_overflow  out  1  sticky: a pixel was dropped because the FIFO was full.

## Operation
- FSM states: S_IDLE, S_ARM, S_CAPTURE, S_DRAIN.
- S_IDLE: ignores the input stream. On i_start_capture it clears o_overflow, x, y and line_base, then goes to S_ARM.
- S_ARM: waits for a frame start, defined as i_fval low in the previous cycle and high in the current cycle. A frame already in progress when S_ARM is entered is skipped. On a frame start it goes to S_CAPTURE.
- S_CAPTURE: each cycle with i_fval&i_lval, if x<H_ACT and y<V_ACT:
  - push {line_base+x, 8'h00, i_pixel} into the FIFO;
  - x+1.
- Falling i_lval with x≠0: line_base += H_ACT, y+1, x=0. Empty lines do not advance y.
- Falling i_fval, or y reaching V_ACT: go to S_DRAIN.
- S_DRAIN: waits until the FIFO is empty, pulses o_done, returns to S_IDLE.
- i_start_capture outside S_IDLE is ignored.
- FIFO:
  - o_wr_req = !empty; o_addr_capture and o_wdata show the head and stay stable until acknowledged.
  - A cycle with o_wr_req&i_wr_ack pops the head. i_wr_ack without o_wr_req is ignored.
  - Push and pop in the same cycle are both honoured; this is legal even when the FIFO is full.
  - A push into a full FIFO with no pop drops the pixel, sets o_overflow, and x still advances, so the address map stays aligned.
- Short frame: fewer than V_ACT lines still ends in S_DRAIN and pulses o_done. Unwritten addresses keep their old contents.
- Arithmetic: line_base is 20 bits. The maximum address is H_ACT·V_ACT−1 = 307199, which fits.

## Timing
- Reset values: o_wr_req 0, o_addr_capture 0, o_wdata 0, o_busy 0, o_done 0, o_overflow 0, state S_IDLE, FIFO empty.
- The input stream is registered once.
- Latency: a pixel sampled at edge k is pushed at edge k+1, and o_wr_req is high after edge k+1 if the FIFO was empty. First-word latency is 2 cycles.
- Sustained throughput is one write per cycle when i_wr_ack is held high.
- o_done is asserted in the cycle after the last pop.
- i_rst asserted mid-frame: all state returns to reset values immediately and queued FIFO entries are discarded.

## Configuration
- CAPTURE_TESTPAT_EN defined: in S_CAPTURE the pushed pixel is x[7:0]^y[7:0] instead of i_pixel. Timing, addressing and handshake are unchanged.
- Not defined: i_pixel is captured. No test-pattern logic is present in the RTL.

## Structure
- Shared package hdr_pkg holds:
  - state enum capture_state_e;
  - H_ACT/V_ACT defaults (shared with the VGA display);
  - SRAM_AW=20 and SRAM_DW=16;
  - the FIFO entry struct {addr, data}.
- Sub-module capture_fifo: synchronous FIFO, parameterised on depth and entry type.
  - Ports: push, pop, full, empty, head.
  - Reset: asynchronous, active-high.

## Test plan
- Full 640×480 frame, i_wr_ack tied 1 → exactly 307200 writes; pixel (x=5,y=2) lands at address 1285; o_done pulses once; o_overflow stays 0.
- i_wr_ack low for 10 cycles mid-line with FIFO_DEPTH=4 → 4 entries are held stable and later pixels are dropped; o_overflow=1; addresses after the stall still follow y·640+x.
- Start pulse mid-frame → the current frame is ignored; capture begins on the next i_fval rise with the first write at address 0.
- Source sends 700-pixel lines and 500 lines → addresses never exceed 307199; o_done follows the 480th line.
- i_rst pulsed while 3 entries are queued → o_wr_req=0 the next cycle; state S_IDLE; o_busy=0.
- CAPTURE_TESTPAT_EN build, frame of 16×4 (H_ACT=16, V_ACT=4) → the word at address 17 equals 16'h0000 (x=1, y=1, 1^1=0); address 18 equals 16'h0003.
